// File: rtl/writeback_sequencer_pkg.sv
// Shared widths and entry format for the write-back sequencer and its queue.
package writeback_sequencer_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 16;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
        src_e                  src;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry FIFO of pending register-file writes; head is read combinationally.
module wb_fifo
    import writeback_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [REG_ADDR_W-1:0]       in_addr,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_src,
    output logic [REG_ADDR_W-1:0]       head_addr,
    output logic [DATA_W-1:0]           head_data,
    output logic                        head_src,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        entries [DEPTH];
    wb_entry_t        in_entry;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign in_entry  = '{addr: in_addr, data: in_data, src: src_e'(in_src)};
    assign head_addr = entries[rd_ptr].addr;
    assign head_data = entries[rd_ptr].data;
    assign head_src  = entries[rd_ptr].src;
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= in_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_sequencer.sv
// Arbitrates ALU and load results into a write-back queue, drains it to the
// register file one entry per cycle, and tracks outstanding destinations.
module writeback_sequencer
    import writeback_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0]     alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0]     mem_data,
    output logic                  mem_ready,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_addr,
    input  logic [REG_ADDR_W-1:0] q1_addr,
    input  logic [REG_ADDR_W-1:0] q2_addr,
    output logic                  q1_busy,
    output logic                  q2_busy,
    input  logic                  wb_stall,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  wb_memtoreg,
    output logic [15:0]           pending
);

    logic                  push;
    logic                  pop;
    logic                  room;
    logic                  full;
    logic                  empty;
    logic [$clog2(DEPTH):0] count_unused;
    logic [REG_ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0]     in_data;
    src_e                  in_src;
    logic [REG_ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0]     head_data;
    logic                  head_src;
    logic [15:0]           pending_next;

    assign pop  = !empty && !wb_stall;
    // A full queue can still take an offer when its head leaves this cycle.
    assign room = !full || pop;

    assign mem_ready = !rst && mem_valid && room;
    assign alu_ready = !rst && alu_valid && !mem_valid && room;

    // Register 0 offers are acknowledged but dropped here.
    assign push    = (mem_ready && (mem_addr != '0)) || (alu_ready && (alu_addr != '0));
    assign in_addr = mem_ready ? mem_addr : alu_addr;
    assign in_data = mem_ready ? mem_data : alu_data;
    assign in_src  = mem_ready ? SRC_MEM : SRC_ALU;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_src    (in_src),
        .head_addr (head_addr),
        .head_data (head_data),
        .head_src  (head_src),
        .full      (full),
        .empty     (empty),
        .count     (count_unused)
    );

    // A new reservation overrides the retirement of the same register.
    always_comb begin
        pending_next = pending;
        if (wb_we) begin
            pending_next[wb_addr] = 1'b0;
        end
        if (iss_valid) begin
            pending_next[iss_addr] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    assign q1_busy = pending[q1_addr];
    assign q2_busy = pending[q2_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_we       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            wb_memtoreg <= 1'b0;
            pending     <= '0;
        end else begin
            wb_we <= pop;
            if (pop) begin
                wb_addr     <= head_addr;
                wb_data     <= head_data;
                wb_memtoreg <= (head_src == SRC_MEM);
            end
            pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_writeback_sequencer.sv
// Directed table, corner sequences and random traffic against a queue-based model.
module tb_writeback_sequencer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_addr;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [3:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        iss_valid;
    logic [3:0]  iss_addr;
    logic [3:0]  q1_addr;
    logic [3:0]  q2_addr;
    logic        q1_busy;
    logic        q2_busy;
    logic        wb_stall;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        wb_memtoreg;
    logic [15:0] pending;

    writeback_sequencer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .iss_valid   (iss_valid),
        .iss_addr    (iss_addr),
        .q1_addr     (q1_addr),
        .q2_addr     (q2_addr),
        .q1_busy     (q1_busy),
        .q2_busy     (q2_busy),
        .wb_stall    (wb_stall),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_memtoreg (wb_memtoreg),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [3:0]  aa;
        logic [15:0] ad;
        logic        mv;
        logic [3:0]  ma;
        logic [15:0] md;
        logic        iv;
        logic [3:0]  ia;
        logic        st;
        logic [3:0]  q1;
        logic [3:0]  q2;
        logic        e_ar;
        logic        e_mr;
        logic        e_we;
        logic [3:0]  e_wa;
        logic [15:0] e_wd;
        logic        e_mtr;
        logic        e_q1b;
    } vec_t;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        logic        mem;
    } ent_t;

    ent_t        mq[$];
    logic        m_we;
    logic [3:0]  m_addr;
    logic [15:0] m_data;
    logic        m_mtr;
    logic [15:0] m_pend;

    int total;
    int bad;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                                input logic mv, input logic [3:0] ma, input logic [15:0] md,
                                input logic iv, input logic [3:0] ia, input logic [3:0] q1,
                                input logic e_ar, input logic e_mr, input logic e_we,
                                input logic [3:0] e_wa, input logic [15:0] e_wd,
                                input logic e_mtr, input logic e_q1b);
        vec_t v;
        v.rst = 1'b0; v.st = 1'b0;
        v.av = av; v.aa = aa; v.ad = ad;
        v.mv = mv; v.ma = ma; v.md = md;
        v.iv = iv; v.ia = ia; v.q1 = q1; v.q2 = q1;
        v.e_ar = e_ar; v.e_mr = e_mr; v.e_we = e_we; v.e_wa = e_wa;
        v.e_wd = e_wd; v.e_mtr = e_mtr; v.e_q1b = e_q1b;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Drive one cycle's inputs just after the edge and wait for them to settle.
    task automatic applyStimulus(input vec_t v);
        rst = v.rst;
        alu_valid = v.av; alu_addr = v.aa; alu_data = v.ad;
        mem_valid = v.mv; mem_addr = v.ma; mem_data = v.md;
        iss_valid = v.iv; iss_addr = v.ia;
        wb_stall = v.st;
        q1_addr = v.q1; q2_addr = v.q2;
        @(negedge clk);
    endtask

    // Compare against the model, advance it by one clock, then move past the edge.
    task automatic modelStep();
        int          sz;
        logic        epop;
        logic        eroom;
        logic        emr;
        logic        ear;
        logic [15:0] newp;
        ent_t        h;
        ent_t        e;
        sz    = mq.size();
        epop  = (sz > 0) && !wb_stall && !rst;
        eroom = (sz < DEPTH) || epop;
        emr   = !rst && mem_valid && eroom;
        ear   = !rst && alu_valid && !mem_valid && eroom;
        checkOutput("mem_ready", mem_ready, emr);
        checkOutput("alu_ready", alu_ready, ear);
        checkOutput("q1_busy", q1_busy, (q1_addr != 0) && m_pend[q1_addr]);
        checkOutput("q2_busy", q2_busy, (q2_addr != 0) && m_pend[q2_addr]);
        checkOutput("wb_we", wb_we, m_we);
        checkOutput("wb_addr", wb_addr, m_addr);
        checkOutput("wb_data", wb_data, m_data);
        checkOutput("wb_memtoreg", wb_memtoreg, m_mtr);
        checkOutput("pending", pending, m_pend);
        if (rst) begin
            mq.delete();
            m_we = 0; m_addr = 0; m_data = 0; m_mtr = 0; m_pend = 0;
        end else begin
            newp = m_pend;
            if (m_we) newp[m_addr] = 1'b0;
            if (iss_valid && iss_addr != 0) newp[iss_addr] = 1'b1;
            m_pend = newp;
            if (epop) begin
                h = mq.pop_front();
                m_we = 1; m_addr = h.addr; m_data = h.data; m_mtr = h.mem;
            end else begin
                m_we = 0;
            end
            if (emr && mem_addr != 0) begin
                e.addr = mem_addr; e.data = mem_data; e.mem = 1'b1;
                mq.push_back(e);
            end else if (ear && alu_addr != 0) begin
                e.addr = alu_addr; e.data = alu_data; e.mem = 1'b0;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[11];
    vec_t v;
    logic [3:0] got[$];

    initial begin
        total = 0;
        bad   = 0;

        tbl[0]  = mk(0, 0, 0,        0, 0, 0,        1, 3, 3, 0, 0, 0, 0, 16'h0000, 0, 0);
        tbl[1]  = mk(1, 3, 16'h1234, 0, 0, 0,        0, 0, 3, 1, 0, 0, 0, 16'h0000, 0, 1);
        tbl[2]  = mk(0, 0, 0,        0, 0, 0,        0, 0, 3, 0, 0, 0, 0, 16'h0000, 0, 1);
        tbl[3]  = mk(0, 0, 0,        0, 0, 0,        0, 0, 3, 0, 0, 1, 3, 16'h1234, 0, 1);
        tbl[4]  = mk(0, 0, 0,        0, 0, 0,        0, 0, 3, 0, 0, 0, 3, 16'h1234, 0, 0);
        tbl[5]  = mk(1, 6, 16'h5555, 1, 5, 16'hAAAA, 0, 0, 5, 0, 1, 0, 3, 16'h1234, 0, 0);
        tbl[6]  = mk(1, 6, 16'h5555, 0, 0, 0,        0, 0, 0, 1, 0, 0, 3, 16'h1234, 0, 0);
        tbl[7]  = mk(0, 0, 0,        0, 0, 0,        0, 0, 0, 0, 0, 1, 5, 16'hAAAA, 1, 0);
        tbl[8]  = mk(1, 0, 16'hFFFF, 0, 0, 0,        0, 0, 0, 1, 0, 1, 6, 16'h5555, 0, 0);
        tbl[9]  = mk(0, 0, 0,        0, 0, 0,        0, 0, 0, 0, 0, 0, 6, 16'h5555, 0, 0);
        tbl[10] = mk(0, 0, 0,        0, 0, 0,        0, 0, 0, 0, 0, 0, 6, 16'h5555, 0, 0);

        v = idle();
        v.rst = 1'b1;
        applyStimulus(v);
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset wb_we", wb_we, 0);
        checkOutput("reset wb_addr", wb_addr, 0);
        checkOutput("reset wb_data", wb_data, 0);
        checkOutput("reset wb_memtoreg", wb_memtoreg, 0);
        checkOutput("reset pending", pending, 0);
        checkOutput("reset alu_ready", alu_ready, 0);
        @(posedge clk);
        #1;
        mq.delete();
        m_we = 0; m_addr = 0; m_data = 0; m_mtr = 0; m_pend = 0;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i]);
            checkOutput("tbl alu_ready", alu_ready, tbl[i].e_ar);
            checkOutput("tbl mem_ready", mem_ready, tbl[i].e_mr);
            checkOutput("tbl wb_we", wb_we, tbl[i].e_we);
            checkOutput("tbl wb_addr", wb_addr, tbl[i].e_wa);
            checkOutput("tbl wb_data", wb_data, tbl[i].e_wd);
            checkOutput("tbl wb_memtoreg", wb_memtoreg, tbl[i].e_mtr);
            checkOutput("tbl q1_busy", q1_busy, tbl[i].e_q1b);
            modelStep();
        end

        // Fill the queue under stall, then overflow by one.
        for (int k = 0; k < 5; k++) begin
            v = idle();
            v.st = 1; v.av = 1; v.aa = 4'(k + 1); v.ad = 16'h0100 + 16'(k);
            applyStimulus(v);
            checkOutput("stall alu_ready", alu_ready, (k < 4) ? 1 : 0);
            modelStep();
        end
        v = idle();
        v.av = 1; v.aa = 5; v.ad = 16'h0104;
        applyStimulus(v);
        checkOutput("full+pop alu_ready", alu_ready, 1);
        modelStep();
        got.delete();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(idle());
            if (wb_we) got.push_back(wb_addr);
            modelStep();
        end
        checkOutput("drain count", got.size(), 5);
        for (int j = 0; j < 5; j++) begin
            checkOutput("drain order", (j < got.size()) ? 32'(got[j]) : 32'hFF, j + 1);
        end

        // Reservation landing on the same cycle as the retiring write.
        v = idle(); v.iv = 1; v.ia = 7;
        applyStimulus(v); modelStep();
        v = idle(); v.av = 1; v.aa = 7; v.ad = 16'h7777;
        applyStimulus(v); modelStep();
        applyStimulus(idle()); modelStep();
        v = idle(); v.iv = 1; v.ia = 7;
        applyStimulus(v);
        checkOutput("r7 strobe", {wb_we, wb_addr}, {1'b1, 4'd7});
        modelStep();
        v = idle(); v.q1 = 7;
        applyStimulus(v);
        checkOutput("r7 set wins", pending[7], 1);
        checkOutput("r7 q1_busy", q1_busy, 1);
        modelStep();

        // Reset with entries still queued.
        for (int k = 0; k < 3; k++) begin
            v = idle();
            v.st = 1; v.iv = 1; v.ia = 4'(8 + k);
            v.av = 1; v.aa = 4'(8 + k); v.ad = 16'hBEE0 + 16'(k);
            applyStimulus(v); modelStep();
        end
        v = idle(); v.rst = 1; v.av = 1; v.aa = 9; v.mv = 1; v.ma = 10;
        applyStimulus(v);
        checkOutput("rst alu_ready", alu_ready, 0);
        checkOutput("rst mem_ready", mem_ready, 0);
        modelStep();
        applyStimulus(idle());
        checkOutput("post-rst pending", pending, 0);
        checkOutput("post-rst wb_we", wb_we, 0);
        modelStep();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(idle());
            checkOutput("post-rst no write", wb_we, 0);
            modelStep();
        end

        for (int n = 0; n < 3000; n++) begin
            v = idle();
            v.rst = ($urandom_range(0, 49) == 0);
            v.av = $urandom_range(0, 1); v.aa = 4'($urandom); v.ad = 16'($urandom);
            v.mv = ($urandom_range(0, 2) == 0); v.ma = 4'($urandom); v.md = 16'($urandom);
            v.iv = ($urandom_range(0, 4) < 2); v.ia = 4'($urandom);
            v.st = ($urandom_range(0, 9) < 3);
            v.q1 = 4'($urandom); v.q2 = 4'($urandom);
            applyStimulus(v);
            modelStep();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_sequencer.md
WRITEBACK_SEQUENCER -- requirements
Module: writeback_sequencer

Interface
REQ-001 Parameter: DEPTH, 4, write-back queue entries; power of two, minimum 2.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous reset, active-high, sampled on posedge clk.
REQ-004 alu_valid  in  1  ALU result offered.
REQ-005 alu_addr  in  4  ALU destination register.
REQ-006 alu_data  in  16  ALU result data.
REQ-007 alu_ready  out  1  ALU result accepted this cycle.
REQ-008 mem_valid  in  1  load data (MDR) offered.
REQ-009 mem_addr  in  4  load destination register.
REQ-010 mem_data  in  16  load data.
REQ-011 mem_ready  out  1  load result accepted this cycle.
REQ-012 iss_valid  in  1  decoder reserves a destination this cycle.
REQ-013 iss_addr  in  4  reserved destination register.
REQ-014 q1_addr, q2_addr  in  4 each  hazard-query register addresses.
REQ-015 q1_busy, q2_busy  out  1 each  queried register has a write pending.
REQ-016 wb_stall  in  1  register-file write port unavailable this cycle.
REQ-017 wb_we  out  1  register-file write strobe (drives C_RegWrite).
REQ-018 wb_addr  out  4  register-file write address.
REQ-019 wb_data  out  16  register-file write data.
REQ-020 wb_memtoreg  out  1  entry came from load path (drives C_MemToReg).
REQ-021 pending  out  16  scoreboard, bit n = register n awaiting write-back.

Function
REQ-022 Queue SHALL be a DEPTH-entry FIFO of {addr, data, src}; count ranges 0..DEPTH.
REQ-023 Acceptance SHALL be one entry per cycle; load path has priority when alu_valid and mem_valid are both high.
REQ-024 mem_ready SHALL equal mem_valid and (count<DEPTH or pop this cycle); alu_ready likewise, additionally gated by not mem_valid.
REQ-025 Offers with addr 0 SHALL be accepted (ready high) but not enqueued; register 0 is never written.
REQ-026 Pop SHALL occur when count>0 and wb_stall low; popped entry drives wb_addr/wb_data/wb_memtoreg with wb_we=1 on the next cycle (registered outputs).
REQ-027 wb_we SHALL be 0 in any cycle following no pop; wb_addr/wb_data hold their last values.
REQ-028 Latency: accept in cycle N into empty queue with wb_stall low -> wb_we=1 in cycle N+2 (enqueue N, pop N+1, strobe N+2).
REQ-029 Push and pop in the same cycle at count=DEPTH SHALL be allowed; count unchanged.
REQ-030 Read/write pointers SHALL wrap modulo DEPTH; FIFO order preserved across wrap.
REQ-031 Scoreboard bit n SHALL set on iss_valid with iss_addr=n (n!=0) and clear when wb_we=1 with wb_addr=n.
REQ-032 Same-cycle set and clear of one bit: set wins.
REQ-033 q1_busy/q2_busy SHALL be combinational pending[q*_addr]; address 0 always reports 0.
REQ-034 pending[0] SHALL be constant 0.

Reset
REQ-035 While rst=1 at a clock edge: count=0, pointers=0, pending=0, wb_we=0, wb_addr=0, wb_data=0, wb_memtoreg=0.
REQ-036 Reset mid-operation SHALL discard queued entries without emitting wb_we; ready outputs low while rst=1.

Structure
REQ-037 Shared package SHALL hold REG_ADDR_W=4, DATA_W=16, and the src encoding (SRC_ALU=0, SRC_MEM=1).
REQ-038 FIFO SHALL be a sub-module wb_fifo (DEPTH, push/pop/full/empty/count); scoreboard and arbitration stay in the top.

Verification
REQ-039 Single ALU write r3=16'h1234 after iss r3, queue empty -> wb_we=1, wb_addr=3, wb_data=16'h1234, wb_memtoreg=0 two cycles later; pending[3] 1 then 0.
REQ-040 Both offers same cycle (mem r5=16'hAAAA, alu r6=16'h5555) -> mem_ready=1, alu_ready=0; r5 written first, r6 next accepted.
REQ-041 wb_stall high, 5 pushes with DEPTH=4 -> 4 accepted, 5th ready=0; release stall -> 4 consecutive strobes in push order, then 5th.
REQ-042 Offer alu r0=16'hFFFF -> alu_ready=1, no wb_we ever; q1_addr=0 -> q1_busy=0.
REQ-043 iss r7 in the same cycle wb_we writes r7 -> pending[7] remains 1.
REQ-044 rst asserted with 3 entries queued -> next cycle count=0, pending=0, wb_we=0; no queued entry written after release.
